yuv_mb_pingpong: RTL and testbench

//  Parametrised raster-to-macroblock reorder buffer for YUV420 video; successor to the single-format yuv_ram.

---
 rtl/yuv_mb_pingpong.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_yuv_mb_pingpong.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_mb_pingpong.sv
// yuv_mb_pingpong: raster-stripe to macroblock reorder buffer for YUV420.
// Two stripe banks share one OUT_BYTES-wide RAM. One bank fills from the byte
// stream while the other drains as Y16x16 / U8x8 / V8x8 macroblocks.
// Optional macro YUV_MB_SIDEBAND_EN adds out_mb_x / out_mb_y / out_mb_first.
module yuv_mb_pingpong #(
    parameter int IMG_W     = 1280,
    parameter int IMG_H     = 720,
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mb_last,
    output logic                   frame_done
`ifdef YUV_MB_SIDEBAND_EN
    ,
    output logic [15:0]            out_mb_x,
    output logic [15:0]            out_mb_y,
    output logic                   out_mb_first
`endif
);

    localparam int W            = OUT_BYTES;
    localparam int DW           = 8 * W;
    localparam int STRIPE_BYTES = 24 * IMG_W;
    localparam int BANK_WORDS   = STRIPE_BYTES / W;
    localparam int RAM_WORDS    = 2 * BANK_WORDS;
    localparam int MB_WORDS     = 384 / W;
    localparam int YW           = 256 / W;
    localparam int CW           = 64 / W;
    localparam int NMB          = IMG_W / 16;
    localparam int NSTRIPE      = IMG_H / 16;
    localparam int AW           = $clog2(RAM_WORDS);
    localparam int BW           = $clog2(STRIPE_BYTES);
    localparam int KW           = $clog2(MB_WORDS);
    localparam int MW           = (NMB > 1) ? $clog2(NMB) : 1;
    localparam int SW           = (NSTRIPE > 1) ? $clog2(NSTRIPE) : 1;
    // Words per macroblock row and per stripe line, for luma and chroma.
    localparam int YRW          = 16 / W;
    localparam int CRW          = 8 / W;
    localparam int YROW         = IMG_W / W;
    localparam int CROW         = IMG_W / (2 * W);
    localparam int U_BASE       = (16 * IMG_W) / W;
    localparam int V_BASE       = (20 * IMG_W) / W;
    // Skid depth behind the registered RAM read; 4 keeps 1 word/cycle.
    localparam int FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILL,
        BANK_FULL,
        BANK_DRAIN
    } bank_state_t;

    // Per-word side information that travels with the RAM data.
    typedef struct packed {
`ifdef YUV_MB_SIDEBAND_EN
        logic [15:0] mb_x;
        logic [15:0] mb_y;
        logic        first;
`endif
        logic        bank;
        logic        bank_last;
        logic        frame_last;
        logic        mb_last;
    } tag_t;

    // ---------------- write side ----------------
    logic [BW-1:0] wr_cnt_reg;
    logic          wr_bank_reg;
    logic [DW-1:0] pack_reg;
    logic          wr_accept;
    logic          wr_last;
    logic          wr_en;
    logic [DW-1:0] pack_word;
    logic [AW-1:0] wr_addr;

    bank_state_t   bank_state_reg  [2];
    bank_state_t   bank_state_next [2];
    logic [1:0]    ev_fill;
    logic [1:0]    ev_full;
    logic [1:0]    ev_start;
    logic [1:0]    ev_empty;

    // ---------------- read side ----------------
    logic          rd_active_reg;
    logic          rd_bank_reg;
    logic [KW-1:0] k_reg;
    logic [MW-1:0] m_reg;
    logic [SW-1:0] stripe_reg;
    logic          rd_start;
    logic          rd_issue;
    logic          k_last;
    logic          m_last;
    logic          s_last;
    logic [31:0]   k32;
    logic [31:0]   m32;
    logic [31:0]   j32;
    logic [31:0]   a32;
    logic [AW-1:0] rd_addr;
    tag_t          issue_tag;

    logic [DW-1:0] mem [0:RAM_WORDS-1];
    logic [DW-1:0] ram_q;
    logic          p_valid_reg;
    tag_t          p_tag_reg;

    tag_t          fifo_tag_reg  [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_reg [FIFO_DEPTH];
    logic [1:0]    fifo_wr_ptr_reg;
    logic [1:0]    fifo_rd_ptr_reg;
    logic [2:0]    fifo_cnt_reg;
    logic          push;
    logic          pop;
    logic          drain_done;
    tag_t          head_tag;

    // Byte packing and write addressing for the current fill bank.
    always_comb begin
        wr_accept = in_valid && in_ready;
        wr_last   = (wr_cnt_reg == BW'(STRIPE_BYTES - 1));
        pack_word = (pack_reg << 8) | DW'(in_data);
        wr_en     = wr_accept && ((32'(wr_cnt_reg) % W) == W - 1);
        wr_addr   = AW'(32'(wr_cnt_reg) / W + (wr_bank_reg ? BANK_WORDS : 0));
    end

    assign in_ready = (bank_state_reg[wr_bank_reg] == BANK_EMPTY) ||
                      (bank_state_reg[wr_bank_reg] == BANK_FILL);

    // Stripe byte counter, packer and fill-bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            pack_reg    <= '0;
        end else if (wr_accept) begin
            pack_reg <= pack_word;
            if (wr_last) begin
                wr_cnt_reg  <= '0;
                wr_bank_reg <= ~wr_bank_reg;
            end else begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end
    end

    // Per-bank transition events; each event can only touch one bank.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_ev
            assign ev_fill[gi]  = wr_accept && (wr_bank_reg == 1'(gi)) && !wr_last;
            assign ev_full[gi]  = wr_accept && (wr_bank_reg == 1'(gi)) && wr_last;
            assign ev_start[gi] = rd_start && (rd_bank_reg == 1'(gi));
            assign ev_empty[gi] = drain_done && (head_tag.bank == 1'(gi));
        end
    endgenerate

    // Bank lifecycle next-state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state_reg[b];
            case (bank_state_reg[b])
                BANK_EMPTY: begin
                    if (ev_full[b])      bank_state_next[b] = BANK_FULL;
                    else if (ev_fill[b]) bank_state_next[b] = BANK_FILL;
                end
                BANK_FILL:  if (ev_full[b])  bank_state_next[b] = BANK_FULL;
                BANK_FULL:  if (ev_start[b]) bank_state_next[b] = BANK_DRAIN;
                BANK_DRAIN: if (ev_empty[b]) bank_state_next[b] = BANK_EMPTY;
                default:    bank_state_next[b] = BANK_EMPTY;
            endcase
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) bank_state_reg[b] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) bank_state_reg[b] <= bank_state_next[b];
        end
    end

    // Banks fill strictly alternately, so the oldest FULL bank is rd_bank_reg.
    always_comb begin
        rd_start = !rd_active_reg && (bank_state_reg[rd_bank_reg] == BANK_FULL);
        rd_issue = rd_active_reg && ((fifo_cnt_reg + 3'(p_valid_reg)) < 3'(FIFO_DEPTH));
        k_last   = (k_reg == KW'(MB_WORDS - 1));
        m_last   = (m_reg == MW'(NMB - 1));
        s_last   = (stripe_reg == SW'(NSTRIPE - 1));
    end

    // Macroblock word address within the draining bank.
    always_comb begin
        k32 = 32'(k_reg);
        m32 = 32'(m_reg);
        j32 = '0;
        if (k32 < YW) begin
            a32 = (k32 / YRW) * YROW + m32 * YRW + k32 % YRW;
        end else if (k32 < YW + CW) begin
            j32 = k32 - YW;
            a32 = U_BASE + (j32 / CRW) * CROW + m32 * CRW + j32 % CRW;
        end else begin
            j32 = k32 - YW - CW;
            a32 = V_BASE + (j32 / CRW) * CROW + m32 * CRW + j32 % CRW;
        end
        rd_addr = AW'(a32 + (rd_bank_reg ? BANK_WORDS : 0));
    end

    // Side information for the word being issued this cycle.
    always_comb begin
        issue_tag            = '0;
        issue_tag.bank       = rd_bank_reg;
        issue_tag.bank_last  = k_last && m_last;
        issue_tag.frame_last = k_last && m_last && s_last;
        issue_tag.mb_last    = k_last;
`ifdef YUV_MB_SIDEBAND_EN
        issue_tag.mb_x       = 16'(m_reg);
        issue_tag.mb_y       = 16'(stripe_reg);
        issue_tag.first      = (k_reg == '0);
`endif
    end

    // Issue engine: walks words, MBs and stripes of the draining bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_active_reg <= 1'b0;
            rd_bank_reg   <= 1'b0;
            k_reg         <= '0;
            m_reg         <= '0;
            stripe_reg    <= '0;
        end else if (rd_start) begin
            rd_active_reg <= 1'b1;
        end else if (rd_issue) begin
            if (k_last) begin
                k_reg <= '0;
                if (m_last) begin
                    m_reg         <= '0;
                    rd_active_reg <= 1'b0;
                    rd_bank_reg   <= ~rd_bank_reg;
                    stripe_reg    <= s_last ? '0 : stripe_reg + 1'b1;
                end else begin
                    m_reg <= m_reg + 1'b1;
                end
            end else begin
                k_reg <= k_reg + 1'b1;
            end
        end
    end

    // Simple dual-port bank RAM with registered read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= pack_word;
        if (rd_issue) ram_q <= mem[rd_addr];
    end

    // Tag stage aligned with the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_reg <= 1'b0;
            p_tag_reg   <= '0;
        end else begin
            p_valid_reg <= rd_issue;
            if (rd_issue) p_tag_reg <= issue_tag;
        end
    end

    assign push       = p_valid_reg;
    assign out_valid  = (fifo_cnt_reg != 3'd0);
    assign pop        = out_valid && out_ready;
    assign head_tag   = fifo_tag_reg[fifo_rd_ptr_reg];
    assign drain_done = pop && head_tag.bank_last;

    // Output skid FIFO; holds the head word stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                fifo_tag_reg[e]  <= '0;
                fifo_data_reg[e] <= '0;
            end
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
            fifo_cnt_reg    <= '0;
        end else begin
            if (push) begin
                fifo_tag_reg[fifo_wr_ptr_reg]  <= p_tag_reg;
                fifo_data_reg[fifo_wr_ptr_reg] <= ram_q;
                fifo_wr_ptr_reg                <= fifo_wr_ptr_reg + 1'b1;
            end
            if (pop) fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
            fifo_cnt_reg <= fifo_cnt_reg + 3'(push) - 3'(pop);
        end
    end

    assign out_data     = out_valid ? fifo_data_reg[fifo_rd_ptr_reg] : '0;
    assign out_mb_last  = out_valid && head_tag.mb_last;
    assign frame_done   = pop && head_tag.frame_last;
`ifdef YUV_MB_SIDEBAND_EN
    assign out_mb_x     = out_valid ? head_tag.mb_x : 16'd0;
    assign out_mb_y     = out_valid ? head_tag.mb_y : 16'd0;
    assign out_mb_first = out_valid && head_tag.first;
`endif

endmodule

// File: tb/tb_yuv_mb_pingpong.sv
// Testbench for yuv_mb_pingpong (IMG_W=32, IMG_H=32, OUT_BYTES=4).
// A stripe-level model rebuilds each macroblock from the accepted bytes and
// a single negedge monitor compares every handshaked word against it.
module tb_yuv_mb_pingpong;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int OB    = 4;
    localparam int SB    = 24 * IMG_W;
    localparam int MBW   = 384 / OB;
    localparam int NMB   = IMG_W / 16;
    localparam int NST   = IMG_H / 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_mb_last;
    logic        frame_done;
`ifdef YUV_MB_SIDEBAND_EN
    logic [15:0] out_mb_x;
    logic [15:0] out_mb_y;
    logic        out_mb_first;
`endif

    yuv_mb_pingpong #(.IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_BYTES(OB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_mb_last(out_mb_last), .frame_done(frame_done)
`ifdef YUV_MB_SIDEBAND_EN
        , .out_mb_x(out_mb_x), .out_mb_y(out_mb_y), .out_mb_first(out_mb_first)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          last;
        bit          fend;
        int          x;
        int          y;
        bit          first;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  cur[$];
    int          model_stripe = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cap  [0:2047];
    logic [31:0] ref1 [0:191];
    int          cap_n = 0;
    int          acc_cnt = 0;
    int          fd_cnt = 0;
    int          fd_idx = -1;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;
    int          rdy_mode = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rebuild every macroblock of the completed stripe straight from the raster.
    function automatic void build_stripe();
        logic [7:0] mbb [384];
        int idx;
        exp_t e;
        for (int m = 0; m < NMB; m++) begin
            idx = 0;
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    mbb[idx] = cur[r * IMG_W + 16 * m + c]; idx++;
                end
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        mbb[idx] = cur[(16 + 4 * p) * IMG_W + r * (IMG_W / 2) + 8 * m + c]; idx++;
                    end
            for (int w = 0; w < MBW; w++) begin
                e.d     = {mbb[4 * w], mbb[4 * w + 1], mbb[4 * w + 2], mbb[4 * w + 3]};
                e.last  = (w == MBW - 1);
                e.fend  = (model_stripe == NST - 1) && (m == NMB - 1) && (w == MBW - 1);
                e.x     = m;
                e.y     = model_stripe;
                e.first = (w == 0);
                expq.push_back(e);
            end
        end
        model_stripe = (model_stripe + 1) % NST;
    endfunction

    // Monitor: input capture into the model and output comparison each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            expq.delete();
            cur.delete();
            model_stripe = 0;
            prev_stall   = 0;
        end else begin
            if (in_valid && in_ready) begin
                cur.push_back(in_data);
                acc_cnt++;
                if (cur.size() == SB) begin
                    build_stripe();
                    cur.delete();
                end
            end
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_last", 64'(out_mb_last), 64'(prev_last));
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_word", 64'(out_data), 64'hDEAD_0000_0000);
                end else if (out_ready) begin
                    e = expq.pop_front();
                    check("word_data", 64'(out_data), 64'(e.d));
                    check("mb_last", 64'(out_mb_last), 64'(e.last));
                    check("frame_done", 64'(frame_done), 64'(e.fend));
`ifdef YUV_MB_SIDEBAND_EN
                    check("mb_x", 64'(out_mb_x), 64'(e.x));
                    check("mb_y", 64'(out_mb_y), 64'(e.y));
                    check("mb_first", 64'(out_mb_first), 64'(e.first));
`endif
                    if (cap_n < 2048) cap[cap_n] = out_data;
                    if (frame_done) begin
                        fd_cnt++;
                        fd_idx = cap_n;
                    end
                    cap_n++;
                end
            end
            if (!(out_valid && out_ready)) check("frame_done_idle", 64'(frame_done), 64'd0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_mb_last;
        end
    end

    // Consumer ready pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom % 2);
        endcase
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int t;
        if (gaps && $urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        acc = 0;
        t   = 0;
        while (!acc && t < 5000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %0b expected 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stripe(input bit gaps);
        for (int i = 0; i < SB; i++) send_byte(8'(i), gaps);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((expq.size() != 0 || out_valid) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_within_budget", 64'(expq.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_mb_last"}, 64'(out_mb_last), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs;
        int n;
        int t;
        int acc0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // Test 1: ordering with the i[7:0] stripe, consumer always ready.
        cap_n = 0; rdy_mode = 1;
        send_stripe(0);
        wait_drain();
        check("t1_count", 64'(cap_n), 64'd192);
        check("t1_mb0_w0", 64'(cap[0]), 64'h0001_0203);
        check("t1_mb0_w4", 64'(cap[4]), 64'h2021_2223);
        check("t1_mb0_w64_u", 64'(cap[64]), 64'h0001_0203);
        check("t1_mb0_w80_v", 64'(cap[80]), 64'h8081_8283);
        check("t1_mb1_w0", 64'(cap[96]), 64'h1011_1213);
        for (int i = 0; i < 192; i++) ref1[i] = cap[i];

        // Test 2: random backpressure and input gaps, same stripe.
        cap_n = 0; rdy_mode = 2;
        send_stripe(1);
        wait_drain();
        check("t2_count", 64'(cap_n), 64'd192);
        diffs = 0;
        for (int i = 0; i < 192; i++) if (cap[i] !== ref1[i]) diffs++;
        check("t2_seq_diffs", 64'(diffs), 64'd0);

        // Test 3: both banks fill while the consumer is stalled.
        rdy_mode = 0; out_ready = 1'b0;
        @(posedge clk); #1;
        acc0 = acc_cnt;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        for (int c = 0; c < 1700; c++) begin
            bit a;
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) in_data = 8'($urandom);
        end
        check("t3_bytes_accepted", 64'(acc_cnt - acc0), 64'd1536);
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rdy_mode = 1; out_ready = 1'b1;
        n = 0; t = 0;
        while (n < 192 && t < 2000) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
            t++;
        end
        check("t3_bank_a_words", 64'(n), 64'd192);
        @(negedge clk);
        check("t3_in_ready_restored", 64'(in_ready), 64'd1);
        wait_drain();

        // Test 4: a full frame back to back, then the next frame's first stripe.
        cap_n = 0; fd_cnt = 0; fd_idx = -1;
        send_stripe(0);
        send_stripe(0);
        send_stripe(0);
        wait_drain();
        check("t4_count", 64'(cap_n), 64'd576);
        check("t4_frame_done_pulses", 64'(fd_cnt), 64'd1);
        check("t4_frame_done_word", 64'(fd_idx), 64'd383);
        check("t4_s3_mb0_w0", 64'(cap[384]), 64'h0001_0203);
        check("t4_s3_mb1_w0", 64'(cap[480]), 64'h1011_1213);

        // Test 5: reset in the middle of a stripe, then a clean stripe.
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        cap_n = 0;
        send_stripe(0);
        wait_drain();
        check("t5_count", 64'(cap_n), 64'd192);
        diffs = 0;
        for (int i = 0; i < 192; i++) if (cap[i] !== ref1[i]) diffs++;
        check("t5_seq_diffs", 64'(diffs), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
